// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_pkg
// Description : Shared widths and forward-select encodings for hazard control.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

   localparam int PC_W_DEF   = 9;
   localparam int DATA_W_DEF = 32;
   localparam int RA_W_DEF   = 5;

   typedef enum logic [1:0] {
      FWD_NONE = 2'b00,
      FWD_WB   = 2'b01,
      FWD_MEM  = 2'b10
   } fwd_sel_e;

   // The EX/MEM result is newer than MEM/WB, so it takes precedence.
   function automatic fwd_sel_e fwd_pick(input logic hit_mem, input logic hit_wb);
      if (hit_mem)
         return FWD_MEM;
      else if (hit_wb)
         return FWD_WB;
      else
         return FWD_NONE;
   endfunction

endpackage : pipe_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
`default_nettype none
// ============================================================================
// Module      : fwd_select
// Description : Operand A/B forwarding selects from EX/MEM and MEM/WB stages.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_select
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int RA_W = RA_W_DEF
) (
   input  logic [RA_W-1:0] ex_rs1,
   input  logic [RA_W-1:0] ex_rs2,
   input  logic [RA_W-1:0] mem_rd,
   input  logic [RA_W-1:0] wb_rd,
   input  logic            mem_regwrite,
   input  logic            wb_regwrite,
   output logic [1:0]      fwd_a,
   output logic [1:0]      fwd_b
);

   logic w_mem_valid;
   logic w_wb_valid;

   // Writes to x0 are discarded, so they never forward.
   assign w_mem_valid = mem_regwrite && (mem_rd != '0);
   assign w_wb_valid  = wb_regwrite  && (wb_rd  != '0);

   assign fwd_a = fwd_pick(w_mem_valid && (mem_rd == ex_rs1),
                           w_wb_valid  && (wb_rd  == ex_rs1));
   assign fwd_b = fwd_pick(w_mem_valid && (mem_rd == ex_rs2),
                           w_wb_valid  && (wb_rd  == ex_rs2));

endmodule : fwd_select
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Branch/jump redirect, flush, forwarding and load-use stall.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int PC_W   = PC_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int RA_W   = RA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [PC_W-1:0]   cur_pc,
   input  logic [DATA_W-1:0] imm,
   input  logic              branch,
   input  logic [1:0]        jump,
   input  logic [1:0]        jalr,
   input  logic [DATA_W-1:0] alu_result,
   output logic [DATA_W-1:0] pc_imm,
   output logic [DATA_W-1:0] pc_four,
   output logic [DATA_W-1:0] br_pc,
   output logic              pc_sel,
   output logic              flush_id_ex,
   output logic              flush_if_id,
   input  logic [RA_W-1:0]   ex_rs1,
   input  logic [RA_W-1:0]   ex_rs2,
   input  logic [RA_W-1:0]   mem_rd,
   input  logic [RA_W-1:0]   wb_rd,
   input  logic              mem_regwrite,
   input  logic              wb_regwrite,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   input  logic [RA_W-1:0]   id_rs1,
   input  logic [RA_W-1:0]   id_rs2,
   input  logic [RA_W-1:0]   ex_rd,
   input  logic              ex_memread,
   output logic              stall
);

   localparam logic [DATA_W-1:0] c_four = DATA_W'(4);

   logic [DATA_W-1:0] w_pc_ext;
   logic              r_flush_if_id;

   assign w_pc_ext = DATA_W'(cur_pc);
   assign pc_imm   = w_pc_ext + imm;
   assign pc_four  = w_pc_ext + c_four;

   // JALR targets are forced halfword-aligned by clearing bit 0.
   always_comb begin
      br_pc  = '0;
      pc_sel = 1'b0;
      if (jalr != 2'b00) begin
         br_pc  = {alu_result[DATA_W-1:1], 1'b0};
         pc_sel = 1'b1;
      end else if (jump != 2'b00) begin
         br_pc  = pc_imm;
         pc_sel = 1'b1;
      end else if (branch && alu_result[0]) begin
         br_pc  = pc_imm;
         pc_sel = 1'b1;
      end
   end

   assign flush_id_ex = pc_sel;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_flush_if_id <= 1'b0;
      else
         r_flush_if_id <= pc_sel;
   end

   assign flush_if_id = r_flush_if_id;

   fwd_select #(
      .RA_W (RA_W)
   ) u_fwd_select (
      .ex_rs1       (ex_rs1),
      .ex_rs2       (ex_rs2),
      .mem_rd       (mem_rd),
      .wb_rd        (wb_rd),
      .mem_regwrite (mem_regwrite),
      .wb_regwrite  (wb_regwrite),
      .fwd_a        (fwd_a),
      .fwd_b        (fwd_b)
   );

   assign stall = ex_memread && (ex_rd != '0) &&
                  ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench with a reference model for pipe_hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

   localparam int PC_W   = 9;
   localparam int DATA_W = 32;
   localparam int RA_W   = 5;

   logic              clk = 1'b0;
   logic              reset;
   logic [PC_W-1:0]   cur_pc;
   logic [DATA_W-1:0] imm;
   logic              branch;
   logic [1:0]        jump;
   logic [1:0]        jalr;
   logic [DATA_W-1:0] alu_result;
   logic [DATA_W-1:0] pc_imm;
   logic [DATA_W-1:0] pc_four;
   logic [DATA_W-1:0] br_pc;
   logic              pc_sel;
   logic              flush_id_ex;
   logic              flush_if_id;
   logic [RA_W-1:0]   ex_rs1, ex_rs2, mem_rd, wb_rd;
   logic              mem_regwrite, wb_regwrite;
   logic [1:0]        fwd_a, fwd_b;
   logic [RA_W-1:0]   id_rs1, id_rs2, ex_rd;
   logic              ex_memread;
   logic              stall;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(
      .PC_W   (PC_W),
      .DATA_W (DATA_W),
      .RA_W   (RA_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .cur_pc       (cur_pc),
      .imm          (imm),
      .branch       (branch),
      .jump         (jump),
      .jalr         (jalr),
      .alu_result   (alu_result),
      .pc_imm       (pc_imm),
      .pc_four      (pc_four),
      .br_pc        (br_pc),
      .pc_sel       (pc_sel),
      .flush_id_ex  (flush_id_ex),
      .flush_if_id  (flush_if_id),
      .ex_rs1       (ex_rs1),
      .ex_rs2       (ex_rs2),
      .mem_rd       (mem_rd),
      .wb_rd        (wb_rd),
      .mem_regwrite (mem_regwrite),
      .wb_regwrite  (wb_regwrite),
      .fwd_a        (fwd_a),
      .fwd_b        (fwd_b),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .ex_rd        (ex_rd),
      .ex_memread   (ex_memread),
      .stall        (stall)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: target arithmetic done in 64-bit then reduced mod 2^32.
   function automatic logic [1:0] m_fwd(input logic [RA_W-1:0] rs);
      if (mem_regwrite && mem_rd != 0 && mem_rd == rs) return 2'd2;
      if (wb_regwrite && wb_rd != 0 && wb_rd == rs)    return 2'd1;
      return 2'd0;
   endfunction

   logic [31:0] m_pc_imm, m_pc_four, m_br_pc;
   logic        m_pc_sel, m_stall, m_flush;
   longint      m_sum_imm, m_sum_four;

   always_comb begin
      m_sum_imm  = longint'(cur_pc) + longint'(imm);
      m_sum_four = longint'(cur_pc) + 64'd4;
      m_pc_imm   = m_sum_imm[31:0];
      m_pc_four  = m_sum_four[31:0];
      m_pc_sel   = (jalr != 0) || (jump != 0) || (branch && alu_result[0]);
      if (jalr != 0)
         m_br_pc = alu_result & 32'hFFFF_FFFE;
      else if (m_pc_sel)
         m_br_pc = m_pc_imm;
      else
         m_br_pc = 32'd0;
      m_stall = ex_memread && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
   end

   always @(posedge clk or posedge reset) begin
      if (reset) m_flush <= 1'b0;
      else       m_flush <= m_pc_sel;
   end

   always @(negedge clk) begin
      chk("m_pc_imm",      pc_imm,      m_pc_imm);
      chk("m_pc_four",     pc_four,     m_pc_four);
      chk("m_br_pc",       br_pc,       m_br_pc);
      chk("m_pc_sel",      32'(pc_sel),      32'(m_pc_sel));
      chk("m_flush_id_ex", 32'(flush_id_ex), 32'(m_pc_sel));
      chk("m_flush_if_id", 32'(flush_if_id), 32'(m_flush));
      chk("m_fwd_a",       32'(fwd_a),       32'(m_fwd(ex_rs1)));
      chk("m_fwd_b",       32'(fwd_b),       32'(m_fwd(ex_rs2)));
      chk("m_stall",       32'(stall),       32'(m_stall));
   end

   task automatic idle();
      cur_pc = '0; imm = '0; branch = 1'b0; jump = 2'b00; jalr = 2'b00; alu_result = '0;
      ex_rs1 = '0; ex_rs2 = '0; mem_rd = '0; wb_rd = '0;
      mem_regwrite = 1'b0; wb_regwrite = 1'b0;
      id_rs1 = '0; id_rs2 = '0; ex_rd = '0; ex_memread = 1'b0;
   endtask

   // Inputs change 1ns after a rising edge; literal checks follow 2ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      step(); step();
      #2;
      chk("rst_flush_if_id", 32'(flush_if_id), 32'd0);
      chk("rst_pc_sel",      32'(pc_sel),      32'd0);
      step();
      reset = 1'b0;

      step();
      cur_pc = 9'h010; imm = 32'h8; branch = 1'b1; alu_result = 32'h1;
      #2;
      chk("bt_pc_imm",  pc_imm,  32'h18);
      chk("bt_pc_four", pc_four, 32'h14);
      chk("bt_br_pc",   br_pc,   32'h18);
      chk("bt_pc_sel",  32'(pc_sel),      32'd1);
      chk("bt_flush_ex",32'(flush_id_ex), 32'd1);
      step();
      chk("bt_flush_if",32'(flush_if_id), 32'd1);

      alu_result = 32'h0;
      #2;
      chk("bnt_pc_sel", 32'(pc_sel), 32'd0);
      chk("bnt_br_pc",  br_pc,       32'h0);
      step();
      chk("bnt_flush_if", 32'(flush_if_id), 32'd0);

      branch = 1'b0; jalr = 2'b01; alu_result = 32'h45;
      #2;
      chk("jalr_br_pc",  br_pc,       32'h44);
      chk("jalr_pc_sel", 32'(pc_sel), 32'd1);
      step();
      jalr = 2'b10; jump = 2'b01; alu_result = 32'h1_0003; cur_pc = 9'h020; imm = 32'h40;
      #2;
      chk("jalr_prio_br_pc", br_pc, 32'h1_0002);

      step();
      jalr = 2'b00; jump = 2'b01; cur_pc = 9'h100; imm = 32'hFFFF_FFF0;
      #2;
      chk("jneg_br_pc",  br_pc,       32'hF0);
      chk("jneg_pc_sel", 32'(pc_sel), 32'd1);
      step();
      jump = 2'b11; cur_pc = 9'h1FF; imm = 32'hFFFF_FFFF;
      #2;
      chk("wrap_pc_four", pc_four, 32'h203);
      chk("wrap_br_pc",   br_pc,   32'h1FE);

      step();
      idle();
      ex_rs1 = 5'd5; ex_rs2 = 5'd5; mem_rd = 5'd5; wb_rd = 5'd5;
      mem_regwrite = 1'b1; wb_regwrite = 1'b1;
      #2;
      chk("fwd_mem_a", 32'(fwd_a), 32'd2);
      chk("fwd_mem_b", 32'(fwd_b), 32'd2);
      step();
      mem_regwrite = 1'b0;
      #2;
      chk("fwd_wb_a", 32'(fwd_a), 32'd1);
      chk("fwd_wb_b", 32'(fwd_b), 32'd1);
      step();
      mem_regwrite = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0;
      #2;
      chk("fwd_x0_a", 32'(fwd_a), 32'd0);
      chk("fwd_x0_b", 32'(fwd_b), 32'd0);

      step();
      idle();
      ex_memread = 1'b1; ex_rd = 5'd3; id_rs2 = 5'd3; id_rs1 = 5'd7;
      #2;
      chk("lu_stall", 32'(stall), 32'd1);
      step();
      ex_rd = 5'd0; id_rs2 = 5'd0;
      #2;
      chk("lu_x0_stall", 32'(stall), 32'd0);
      step();
      ex_rd = 5'd3; id_rs2 = 5'd3; ex_memread = 1'b0;
      #2;
      chk("lu_nold_stall", 32'(stall), 32'd0);

      step();
      idle();
      jump = 2'b01;
      step();
      chk("ar_pre_flush", 32'(flush_if_id), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("ar_flush_if", 32'(flush_if_id), 32'd0);
      chk("ar_pc_sel",   32'(pc_sel),      32'd1);
      step();
      reset = 1'b0;
      step();
      chk("ar_resume", 32'(flush_if_id), 32'd1);

      for (int i = 0; i < 60; i++) begin
         step();
         cur_pc       = PC_W'($urandom);
         imm          = $urandom;
         branch       = 1'($urandom);
         jump         = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         jalr         = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         alu_result   = $urandom;
         ex_rs1       = RA_W'($urandom_range(0, 3));
         ex_rs2       = RA_W'($urandom_range(0, 3));
         mem_rd       = RA_W'($urandom_range(0, 3));
         wb_rd        = RA_W'($urandom_range(0, 3));
         mem_regwrite = 1'($urandom);
         wb_regwrite  = 1'($urandom);
         id_rs1       = RA_W'($urandom_range(0, 3));
         id_rs2       = RA_W'($urandom_range(0, 3));
         ex_rd        = RA_W'($urandom_range(0, 3));
         ex_memread   = 1'($urandom);
      end

      step(); step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
